// File: rtl/bg_scroll_ctrl.sv
// Background scroll registers (double-buffered at blanking), scrolled pixel coordinates and Z80 BG RAM arbitration.
// Coordinates lag pixel_ce by 1 clk; CPU is stalled via BG_WAIT until the next free tile slot, blanking or timeout.
module bg_scroll_ctrl #(
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic        master_clk,
   input  logic        reset_n,
   input  logic        pixel_ce,
   input  logic [8:0]  HPIX,
   input  logic [7:0]  VPIX,
   input  logic        HBLANK,
   input  logic        VBLANK,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DIN,
   input  logic        Z80_WR,
   input  logic        SCROLL_CS,
   input  logic        BG_RAM_CS,
   output logic [8:0]  HPIXSCRL,
   output logic [7:0]  VPIXSCRL,
   output logic        BG_WAIT,
   output logic        CPU_RAM_SYNC,
   output logic [8:0]  SCRL_X_out,
   output logic [7:0]  SCRL_Y_out
);
   localparam int CW = $clog2(WAIT_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_GRANT = 2'd2
   } arb_state_t;

   arb_state_t state, state_nxt;

   logic          wr_q, cs_q, hb_q, vb_q;
   logic [8:0]    pend_x, act_x;
   logic [7:0]    pend_y, act_y;
   logic [8:0]    hsum;
   logic [7:0]    vsum;
   logic          scroll_wr, hb_rise, vb_rise, cs_fall, blank, slot, timeout;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          sync_due, sync_due_nxt, bg_wait_nxt, sync_nxt, grant_pix;
   logic          unused_addr;

   assign unused_addr = ^CPU_ADDR[15:2];

   assign scroll_wr = ~SCROLL_CS & wr_q & ~Z80_WR;
   assign hb_rise   = HBLANK & ~hb_q;
   assign vb_rise   = VBLANK & ~vb_q;
   assign cs_fall   = cs_q & ~BG_RAM_CS;
   assign blank     = HBLANK | VBLANK;

   // Sums wrap naturally at the coordinate widths.
   assign hsum    = HPIX + act_x;
   assign vsum    = VPIX + act_y;
   assign slot    = (hsum[2:0] == 3'b111);
   assign timeout = (wait_cnt == CW'(WAIT_TIMEOUT - 1));

   assign SCRL_X_out = act_x;
   assign SCRL_Y_out = act_y;

   // Latches read pend_* before this cycle's write lands, so a coincident write waits a frame/line.
   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q     <= 1'b1;
         cs_q     <= 1'b1;
         hb_q     <= 1'b0;
         vb_q     <= 1'b0;
         pend_x   <= '0;
         pend_y   <= '0;
         act_x    <= '0;
         act_y    <= '0;
         HPIXSCRL <= '0;
         VPIXSCRL <= '0;
      end else begin
         wr_q <= Z80_WR;
         cs_q <= BG_RAM_CS;
         hb_q <= HBLANK;
         vb_q <= VBLANK;
         if (hb_rise) act_x <= pend_x;
         if (vb_rise) act_y <= pend_y;
         if (scroll_wr) begin
            case (CPU_ADDR[1:0])
               2'd0:    pend_x[7:0] <= CPU_DIN;
               2'd1:    pend_x[8]   <= CPU_DIN[0];
               2'd2:    pend_y      <= CPU_DIN;
               default: ;
            endcase
         end
         if (pixel_ce) begin
            HPIXSCRL <= hsum;
            VPIXSCRL <= vsum;
         end
      end
   end

   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         sync_due     <= 1'b0;
         BG_WAIT      <= 1'b1;
         CPU_RAM_SYNC <= 1'b1;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         sync_due     <= sync_due_nxt;
         BG_WAIT      <= bg_wait_nxt;
         CPU_RAM_SYNC <= sync_nxt;
      end
   end

   // A blanking-time grant enters GRANT off the pixel grid, so its slot strobe is deferred to the next pixel_ce.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      sync_due_nxt = sync_due;
      bg_wait_nxt  = BG_WAIT;
      sync_nxt     = CPU_RAM_SYNC;
      grant_pix    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_fall) begin
               if (blank) begin
                  state_nxt    = ST_GRANT;
                  sync_due_nxt = 1'b1;
               end else begin
                  state_nxt    = ST_WAIT;
                  bg_wait_nxt  = 1'b0;
                  wait_cnt_nxt = '0;
               end
            end
         end
         ST_WAIT: begin
            if (BG_RAM_CS) begin
               state_nxt   = ST_IDLE;
               bg_wait_nxt = 1'b1;
            end else if (pixel_ce) begin
               if (slot || blank || timeout) begin
                  state_nxt = ST_GRANT;
                  grant_pix = 1'b1;
               end else begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
            end
         end
         ST_GRANT: begin
            bg_wait_nxt = 1'b1;
            if (pixel_ce && sync_due) begin
               grant_pix    = 1'b1;
               sync_due_nxt = 1'b0;
            end
            if (BG_RAM_CS) begin
               state_nxt    = ST_IDLE;
               sync_due_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (pixel_ce) sync_nxt = ~grant_pix;
   end
endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed literal checks plus randomized video/CPU traffic compared every cycle against a behavioural model.
module tb_bg_scroll_ctrl;
   localparam int TO = 16;

   logic        master_clk = 1'b0;
   logic        reset_n, pixel_ce, HBLANK, VBLANK, Z80_WR, SCROLL_CS, BG_RAM_CS;
   logic [8:0]  HPIX;
   logic [7:0]  VPIX;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DIN;
   logic [8:0]  HPIXSCRL, SCRL_X_out;
   logic [7:0]  VPIXSCRL, SCRL_Y_out;
   logic        BG_WAIT, CPU_RAM_SYNC;

   int n_vec = 0;
   int n_bad = 0;

   // model state
   logic [8:0] m_pend_x, m_act_x, m_h;
   logic [7:0] m_pend_y, m_act_y, m_v;
   logic       m_wait, m_sync, m_due, m_wr_prev, m_cs_prev, m_hb_prev, m_vb_prev;
   logic       m_blank, m_slot, m_grant;
   int         m_phase, m_cnt, m_hsum, m_vsum;   // phase: 0 no access, 1 CPU held, 2 CPU owns slot

   always #5 master_clk = ~master_clk;

   bg_scroll_ctrl #(.WAIT_TIMEOUT(TO)) dut (
      .master_clk(master_clk), .reset_n(reset_n), .pixel_ce(pixel_ce),
      .HPIX(HPIX), .VPIX(VPIX), .HBLANK(HBLANK), .VBLANK(VBLANK),
      .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .Z80_WR(Z80_WR),
      .SCROLL_CS(SCROLL_CS), .BG_RAM_CS(BG_RAM_CS),
      .HPIXSCRL(HPIXSCRL), .VPIXSCRL(VPIXSCRL), .BG_WAIT(BG_WAIT),
      .CPU_RAM_SYNC(CPU_RAM_SYNC), .SCRL_X_out(SCRL_X_out), .SCRL_Y_out(SCRL_Y_out)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_h = 0; m_v = 0;
      m_wait = 1; m_sync = 1; m_due = 0; m_phase = 0; m_cnt = 0;
      m_wr_prev = 1; m_cs_prev = 1; m_hb_prev = 0; m_vb_prev = 0;
   endtask

   // One clock of the rules: offsets add modulo the coordinate range, buffers load at blank onset,
   // the CPU is held until a tile's last pixel (or blanking / timeout) and then owns one pixel slot.
   task automatic model_step();
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_hsum  = (int'(HPIX) + int'(m_act_x)) % 512;
      m_vsum  = (int'(VPIX) + int'(m_act_y)) % 256;
      m_blank = HBLANK || VBLANK;
      m_slot  = (m_hsum % 8) == 7;
      m_grant = 0;
      if (HBLANK && !m_hb_prev) m_act_x = m_pend_x;
      if (VBLANK && !m_vb_prev) m_act_y = m_pend_y;
      if (!SCROLL_CS && m_wr_prev && !Z80_WR) begin
         if (CPU_ADDR[1:0] == 2'd0) m_pend_x = {m_pend_x[8], CPU_DIN};
         else if (CPU_ADDR[1:0] == 2'd1) m_pend_x = {CPU_DIN[0], m_pend_x[7:0]};
         else if (CPU_ADDR[1:0] == 2'd2) m_pend_y = CPU_DIN;
      end
      if (pixel_ce) begin
         m_h = 9'(m_hsum);
         m_v = 8'(m_vsum);
      end
      if (m_phase == 0) begin
         if (m_cs_prev && !BG_RAM_CS) begin
            if (m_blank) begin m_phase = 2; m_due = 1; end
            else begin m_phase = 1; m_wait = 0; m_cnt = 0; end
         end
      end else if (m_phase == 1) begin
         if (BG_RAM_CS) begin m_phase = 0; m_wait = 1; end
         else if (pixel_ce) begin
            if (m_slot || m_blank || m_cnt == TO - 1) begin m_phase = 2; m_grant = 1; end
            else m_cnt++;
         end
      end else begin
         m_wait = 1;
         if (pixel_ce && m_due) begin m_grant = 1; m_due = 0; end
         if (BG_RAM_CS) begin m_phase = 0; m_due = 0; end
      end
      if (pixel_ce) m_sync = !m_grant;
      m_wr_prev = Z80_WR; m_cs_prev = BG_RAM_CS; m_hb_prev = HBLANK; m_vb_prev = VBLANK;
   endtask

   task automatic check_model();
      chk("hpixscrl", int'(HPIXSCRL), int'(m_h));
      chk("vpixscrl", int'(VPIXSCRL), int'(m_v));
      chk("bg_wait", int'(BG_WAIT), int'(m_wait));
      chk("cpu_ram_sync", int'(CPU_RAM_SYNC), int'(m_sync));
      chk("scrl_x_out", int'(SCRL_X_out), int'(m_act_x));
      chk("scrl_y_out", int'(SCRL_Y_out), int'(m_act_y));
   endtask

   task automatic tick();
      @(posedge master_clk);
      model_step();
      @(negedge master_clk);
      check_model();
   endtask

   task automatic pix();
      pixel_ce = 1; tick();
      pixel_ce = 0; tick(); tick(); tick();
   endtask

   task automatic scroll_write(input logic [1:0] a, input logic [7:0] d);
      CPU_ADDR = {14'd0, a}; CPU_DIN = d; SCROLL_CS = 0; Z80_WR = 0;
      tick(); tick();
      Z80_WR = 1; SCROLL_CS = 1;
      tick();
   endtask

   initial begin
      int cnt, low_seen, pulses, hcnt, vcnt, wr_left, cs_hold, abort_at, cs_gap;
      logic prev_sync;
      reset_n = 0; pixel_ce = 0; HPIX = 0; VPIX = 0; HBLANK = 0; VBLANK = 0;
      CPU_ADDR = 0; CPU_DIN = 0; Z80_WR = 1; SCROLL_CS = 1; BG_RAM_CS = 1;
      model_reset();
      tick(); tick();
      chk("rst_hpixscrl", HPIXSCRL, 0);
      chk("rst_bg_wait", BG_WAIT, 1);
      chk("rst_sync", CPU_RAM_SYNC, 1);
      reset_n = 1; tick();

      // double-buffered X
      scroll_write(2'd0, 8'h20);
      scroll_write(2'd1, 8'h01);
      HPIX = 9'h0F0; pix();
      chk("x_before_hblank", HPIXSCRL, 'h0F0);
      HBLANK = 1; tick(); tick(); HBLANK = 0; tick();
      pix();
      chk("x_after_hblank", HPIXSCRL, 'h010);
      chk("x_readback", SCRL_X_out, 'h120);

      // Y wrap, addr3 ignored
      scroll_write(2'd2, 8'hF8);
      scroll_write(2'd3, 8'h55);
      VPIX = 8'h10; pix();
      chk("y_before_vblank", VPIXSCRL, 'h10);
      VBLANK = 1; tick(); tick();
      pix();
      chk("y_wrap", VPIXSCRL, 'h08);
      chk("y_readback", SCRL_Y_out, 'hF8);
      HBLANK = 1; tick(); HBLANK = 0; tick();
      chk("addr3_no_x_change", SCRL_X_out, 'h120);
      VBLANK = 0; tick();

      // active-display access starting at tile pixel 2
      HPIX = 9'h0E2; pix();
      chk("act_start_pixel", HPIXSCRL[2:0], 2);
      BG_RAM_CS = 0; tick();
      chk("act_wait_fell", BG_WAIT, 0);
      cnt = 0;
      for (int i = 0; i < 12 && BG_WAIT == 1'b0; i++) begin
         cnt++; HPIX = HPIX + 9'd1; pix();
      end
      chk("act_wait_pixels", cnt, 5);
      chk("act_sync_low", CPU_RAM_SYNC, 0);
      chk("act_sync_slot", HPIXSCRL[2:0], 7);
      pix();
      chk("act_sync_high", CPU_RAM_SYNC, 1);
      BG_RAM_CS = 1; tick(); tick();

      // blanking access
      VBLANK = 1; tick(); tick();
      low_seen = 0; pulses = 0; prev_sync = CPU_RAM_SYNC;
      BG_RAM_CS = 0;
      for (int t = 0; t < 16; t++) begin
         pixel_ce = (t % 4 == 0); tick();
         if (!BG_WAIT) low_seen++;
         if (prev_sync && !CPU_RAM_SYNC) pulses++;
         prev_sync = CPU_RAM_SYNC;
      end
      pixel_ce = 0; BG_RAM_CS = 1; tick(); tick(); VBLANK = 0; tick();
      chk("blank_wait_low_cycles", low_seen, 0);
      chk("blank_sync_pulses", pulses, 1);

      // aborted access
      HPIX = 9'h0E0; pix();
      BG_RAM_CS = 0; tick();
      chk("abort_wait_fell", BG_WAIT, 0);
      pulses = 0;
      HPIX = HPIX + 9'd1; pix(); if (!CPU_RAM_SYNC) pulses++;
      HPIX = HPIX + 9'd1; pix(); if (!CPU_RAM_SYNC) pulses++;
      BG_RAM_CS = 1; tick();
      chk("abort_wait_release", BG_WAIT, 1);
      for (int i = 0; i < 8; i++) begin
         HPIX = HPIX + 9'd1; pix(); if (!CPU_RAM_SYNC) pulses++;
      end
      chk("abort_sync_pulses", pulses, 0);

      // write coincident with VBLANK rise
      scroll_write(2'd2, 8'h40);
      CPU_ADDR = 16'd2; CPU_DIN = 8'h30; SCROLL_CS = 0; Z80_WR = 0; VBLANK = 1;
      tick();
      Z80_WR = 1; SCROLL_CS = 1; tick();
      chk("coincident_old_y", SCRL_Y_out, 'h40);
      VPIX = 8'h10; pix();
      chk("coincident_vpixscrl", VPIXSCRL, 'h50);
      VBLANK = 0; tick(); VBLANK = 1; tick();
      chk("coincident_next_frame", SCRL_Y_out, 'h30);
      VBLANK = 0; tick();

      // reset while CPU is held
      HPIX = 9'h0E0; pix();
      BG_RAM_CS = 0; tick();
      chk("midwait_pre", BG_WAIT, 0);
      reset_n = 0; model_reset();
      #1;
      chk("midwait_rst_wait", BG_WAIT, 1);
      chk("midwait_rst_sync", CPU_RAM_SYNC, 1);
      chk("midwait_rst_h", HPIXSCRL, 0);
      chk("midwait_rst_v", VPIXSCRL, 0);
      chk("midwait_rst_x", SCRL_X_out, 0);
      BG_RAM_CS = 1; tick(); tick();
      reset_n = 1; tick();
      HPIX = 9'h055; pix();
      chk("post_rst_hpixscrl", HPIXSCRL, 'h055);

      // randomized frames
      hcnt = 0; vcnt = 0; wr_left = 0; cs_hold = 0; abort_at = -1; cs_gap = 0;
      for (int c = 0; c < 16000; c++) begin
         tick();
         if (pixel_ce) begin
            hcnt = (hcnt + 1) % 64;
            if (hcnt == 0) vcnt = (vcnt + 1) % 20;
         end
         pixel_ce = (c % 4 == 3);
         HPIX = 9'(hcnt + 440);
         VPIX = 8'(vcnt + 240);
         HBLANK = (hcnt >= 48);
         VBLANK = (vcnt >= 16);
         if (wr_left > 0) begin
            wr_left--;
            if (wr_left == 0) begin Z80_WR = 1; SCROLL_CS = 1; end
         end else if ($urandom_range(0, 29) == 0) begin
            CPU_ADDR  = 16'($urandom);
            CPU_DIN   = 8'($urandom);
            SCROLL_CS = ($urandom_range(0, 7) == 0);
            Z80_WR    = 0;
            wr_left   = $urandom_range(1, 4);
         end
         if (cs_gap > 0) cs_gap--;
         else if (BG_RAM_CS) begin
            if ($urandom_range(0, 19) == 0) begin
               BG_RAM_CS = 0; cs_hold = 0;
               abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            end
         end else begin
            cs_hold++;
            if (cs_hold == abort_at || (cs_hold >= 6 && BG_WAIT)) begin
               BG_RAM_CS = 1; cs_gap = $urandom_range(1, 5);
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/bg_scroll_ctrl.md
# bg_scroll_ctrl

Scroll and CPU-arbitration stage directly upstream of the background layer renderer. It holds the CPU-written background scroll registers and double-buffers them so updates land only at blanking. It produces the scrolled pixel coordinates `HPIXSCRL`/`VPIXSCRL` that address background RAM and ROM. It also arbitrates Z80 access to background RAM, generating `BG_WAIT` and the `CPU_RAM_SYNC` slot strobe that the renderer consumes.

## Interface
Parameters:
- `WAIT_TIMEOUT`, 16: maximum `pixel_ce` pulses a CPU access may be held before a forced grant.

Ports (one clock; reset is asynchronous and active-low):
- `master_clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pixel_ce`  in  1  one-`master_clk`-wide pixel enable.
- `HPIX`  in  9  raw horizontal pixel counter.
- `VPIX`  in  8  raw vertical line counter.
- `HBLANK`  in  1  active-high horizontal blank.
- `VBLANK`  in  1  active-high vertical blank.
- `CPU_ADDR`  in  16  Z80 address; only `[1:0]` used here.
- `CPU_DIN`  in  8  Z80 write data.
- `Z80_WR`  in  1  Z80 write strobe, active low.
- `SCROLL_CS`  in  1  decoded scroll-register select, active low.
- `BG_RAM_CS`  in  1  decoded background RAM select, active low (AND of both BG RAM selects).
- `HPIXSCRL`  out  9  scrolled horizontal coordinate.
- `VPIXSCRL`  out  8  scrolled vertical coordinate.
- `BG_WAIT`  out  1  Z80 wait request, active low.
- `CPU_RAM_SYNC`  out  1  CPU access slot strobe, active low, one `pixel_ce` period wide.
- `SCRL_X_out`  out  9  active X scroll value, for debug/readback.
- `SCRL_Y_out`  out  8  active Y scroll value, for debug/readback.

## Operation
- **Write detect:** a write is `SCROLL_CS`=0 and `Z80_WR` going from 1 to 0, sampled on consecutive `master_clk` edges. There is exactly one write per strobe.
- **Write decode on `CPU_ADDR[1:0]`:**
  - 0: `pend_x[7:0]` ← `CPU_DIN`
  - 1: `pend_x[8]` ← `CPU_DIN[0]`
  - 2: `pend_y` ← `CPU_DIN`
  - 3: ignored
- **Buffering:**
  - `act_x` ← `pend_x` on the `HBLANK` rising edge.
  - `act_y` ← `pend_y` on the `VBLANK` rising edge.
  - Edges are detected synchronously.
  - If a pending write and a latch occur in the same cycle, the latch takes the pre-write pending value.
- **Coordinates:** on each `pixel_ce`, register the following (no saturation):
  - `HPIXSCRL` = (`HPIX` + `act_x`) mod 512
  - `VPIXSCRL` = (`VPIX` + `act_y`) mod 256
- **Screen flip:** applied downstream, not here.
- **CPU slot:** the slot is the `pixel_ce` where the next `HPIXSCRL[2:0]` equals 3'b111. That is the last pixel of each 8-pixel tile, where the renderer does not fetch.
- **Arbitration FSM:**
  - **IDLE:**
    - Stays here while `BG_RAM_CS`=1.
    - On `BG_RAM_CS` falling during `HBLANK|VBLANK`: go to GRANT immediately, `BG_WAIT` stays 1.
    - Otherwise: go to WAIT, `BG_WAIT`←0, clear the timeout counter.
  - **WAIT:**
    - Count `pixel_ce` pulses.
    - At the next CPU slot, or when count = `WAIT_TIMEOUT`-1: go to GRANT, `CPU_RAM_SYNC`←0 for that pixel, `BG_WAIT`←1 on the next `master_clk`.
    - If blanking begins while in WAIT: grant at the next `pixel_ce`.
  - **GRANT:**
    - `CPU_RAM_SYNC` returns to 1 at the next `pixel_ce`.
    - Remain in GRANT until `BG_RAM_CS`=1, then go to IDLE.
    - A second access needs `BG_RAM_CS` to rise and fall again.
  - If `BG_RAM_CS` rises during WAIT (aborted access): go to IDLE, `BG_WAIT`←1, and no `CPU_RAM_SYNC` pulse is issued.
- **Reset values:**
  - Zero: `pend_x`, `pend_y`, `act_x`, `act_y`, `HPIXSCRL`, `VPIXSCRL`.
  - Outputs: `BG_WAIT`=1, `CPU_RAM_SYNC`=1.
  - FSM: IDLE, all edge detectors primed to the inactive level.
- **Reset mid-wait:** `BG_WAIT` releases to 1 asynchronously.

## Timing
- Scroll write to `pend_*`: 1 `master_clk` after the `Z80_WR` falling edge is sampled.
- `act_x` is visible in `HPIXSCRL` at the first `pixel_ce` after the `HBLANK` rising edge.
- `act_y` is visible in `VPIXSCRL` at the first `pixel_ce` after the `VBLANK` rising edge.
- `HPIXSCRL`/`VPIXSCRL` latency: 1 `master_clk` after the `pixel_ce` that presents `HPIX`/`VPIX`.
- `BG_WAIT` falls 1 `master_clk` after `BG_RAM_CS` falling is sampled (active display).
- Worst-case wait: 8 `pixel_ce` in active display (slot every 8 pixels); hard limit `WAIT_TIMEOUT`.
- `CPU_RAM_SYNC` is low for exactly one `pixel_ce` interval.
- `SCRL_X_out`/`SCRL_Y_out` equal `act_x`/`act_y` combinationally.

## Test plan
- **Reset:** assert `reset_n`=0 mid-frame with `BG_WAIT` low → `BG_WAIT`=1, `CPU_RAM_SYNC`=1, `HPIXSCRL`=0, `VPIXSCRL`=0 immediately; after release with `HPIX`=0x055 → `HPIXSCRL`=0x055.
- **Double-buffered X:** write addr0=0x20, addr1=0x01 mid-line → `HPIXSCRL` unchanged until `HBLANK` rises. Afterwards `HPIX`=0x0F0 gives `HPIXSCRL`=0x010 (0x0F0+0x120 mod 512), and `SCRL_X_out`=0x120.
- **Y wrap:** write addr2=0xF8 during active display, wait for `VBLANK` rise → `VPIX`=0x10 gives `VPIXSCRL`=0x08. A write to addr3 changes no register.
- **Active-display access:** `BG_RAM_CS` falls when `HPIXSCRL[2:0]`=3'b010 → `BG_WAIT`=0 for 5 `pixel_ce`. `CPU_RAM_SYNC` is low exactly on the pixel where `HPIXSCRL[2:0]`=3'b111, then `BG_WAIT`=1.
- **Blanking access:** `BG_RAM_CS` falls during `VBLANK` → `BG_WAIT` never goes low, one `CPU_RAM_SYNC` pulse.
- **Abort and simultaneous write/latch:** with `BG_RAM_CS` released during WAIT → IDLE, no `CPU_RAM_SYNC` pulse. With an addr2 write coincident with the `VBLANK` rise → `act_y` takes the old value, and the new value takes effect the next frame.
